pattern_scan_ctrl: RTL
======================

# pattern_scan_ctrl

Scan controller that takes a parallel word, serialises it MSB-first into an overlapping 4-bit Mealy sequence detector, and reports the match count and the first match position. It sits between a register-level requester (start/done handshake) and the serial detector datapath. It owns sequencing, history clearing, counting and result holding.

## Interface
Parameters:
- DATA_W, 16, scan word width; legal range ≥ 4.
- CNT_W, 5, width of count and position outputs; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  scan request; sampled only in IDLE.
- data_in  input  DATA_W  word to scan; captured on the accepted start.
- pattern  input  4  pattern to detect, MSB = first bit; captured on the accepted start.
- busy  output  1  high while scanning.
- done  output  1  one-cycle pulse at scan end.
- hit  output  1  one-cycle pulse, registered, for each match.
- match_cnt  output  CNT_W  number of matches in the last scan.
- found  output  1  at least one match in the last scan.
- first_pos  output  CNT_W  bit index of the first bit of the first match, with index 0 = MSB. Valid only when found=1; otherwise 0.

## Operation
- Reset (async, any state): state=IDLE; busy, done, hit, found = 0; match_cnt = 0; first_pos = 0; shift register, bit index and detector history cleared.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE to SHIFT when start=1.
  - SHIFT to DONE after DATA_W bits.
  - DONE to IDLE unconditionally after one cycle.
- On the accepted start:
  - Latch data_in and pattern.
  - Clear detector history, match_cnt, found and first_pos.
  - Set bit index to 0.
- SHIFT: one bit per cycle, MSB first.
  - The detector keeps a 3-bit history of prior bits.
  - A match occurs when {history, current bit} == pattern and at least 4 bits have been shifted in this scan.
  - Overlap is allowed: history is not cleared on a match.
  - History never carries across scans.
- On each match:
  - match_cnt increments (saturating is not needed; DATA_W-3 < 2^CNT_W).
  - hit pulses.
  - On the first match only: found=1 and first_pos = current index − 3.
- start is ignored in SHIFT and DONE; there is no queuing.
- Results (match_cnt, found, first_pos) hold from done until the next accepted start.
- Changes on data_in and pattern after capture have no effect.

## Timing
- Let E0 be the edge at which start=1 is sampled in IDLE.
  - busy=1 from E0 through E(DATA_W); it drops at the edge where done rises.
  - Bit i (i = 0..DATA_W-1) is evaluated at edge E(i+1).
  - A hit for a match ending at bit i is visible in the cycle after E(i+1).
  - match_cnt, found and first_pos update at the same edge as hit.
  - At E(DATA_W) the FSM enters DONE: done=1 and busy=0 for that one cycle.
  - At E(DATA_W+1) the FSM returns to IDLE.
- The earliest next start is accepted at E(DATA_W+1), giving a scan period of DATA_W+1 cycles.
- Reset asserted mid-scan aborts immediately with no done pulse. The first start after rst falls is accepted normally.

## Structure
- Shared package holds:
  - the FSM state enum (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10);
  - the PAT_W=4 constant.
- One sub-module, `seq_det4`: programmable overlapping 4-bit Mealy detector.
  - Inputs: clk, rst, clr, en, bit_in, pattern.
  - Output: a combinational match, qualified by en and a 4-bit-fill counter.
- The top level holds the FSM, the data shift register, the bit index, the counters and the output registers.

## Test plan
- Reset state: reset held high.
  - Required: all outputs 0, and start is ignored while rst=1.
- Single match: data_in=16'hB000, pattern=4'b1011.
  - Required: one hit in the cycle after E4; done after E16; match_cnt=1, found=1, first_pos=0.
- Overlapping matches: data_in=16'b1011011011000000, pattern=4'b1011.
  - Required: hits after E4, E7 and E10; match_cnt=3, first_pos=0.
- No match: data_in=16'hFFFF, pattern=4'b1011.
  - Required: no hit; match_cnt=0, found=0, first_pos=0.
- Maximum count: data_in=16'h0000, pattern=4'b0000.
  - Required: match_cnt=13, first_pos=0.
- Busy and reset behaviour:
  - Scan 1: data_in=16'h0B00, pattern=4'b1011. Required: first_pos=4, match_cnt=1.
  - start pulsed at E5 of scan 1 is ignored (scan period unchanged).
  - Scan 2: a new scan with rst pulsed at E8. Required: busy=0, match_cnt=0, no done pulse.

Source files
------------

// File: rtl/pattern_scan_ctrl_pkg.sv
// Shared types and constants for the pattern scan controller and its detector.
package pattern_scan_ctrl_pkg;

  localparam int PAT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// Requester-side handshake and result bus of the pattern scan controller.
interface pattern_scan_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
);
  import pattern_scan_ctrl_pkg::*;

  logic              start;
  logic [DATA_W-1:0] data_in;
  logic [PAT_W-1:0]  pattern;
  logic              busy;
  logic              done;
  logic              hit;
  logic [CNT_W-1:0]  match_cnt;
  logic              found;
  logic [CNT_W-1:0]  first_pos;

  modport master (
    output start, data_in, pattern,
    input  busy, done, hit, match_cnt, found, first_pos
  );

  modport slave (
    input  start, data_in, pattern,
    output busy, done, hit, match_cnt, found, first_pos
  );

endinterface

// File: rtl/pattern_scan_ctrl_seq_det4.sv
// Programmable overlapping 4-bit Mealy sequence detector with a fill counter so
// no match is reported before a full window of bits has been seen.
module seq_det4
  import pattern_scan_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             match
);

  localparam int FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

  logic [PAT_W-2:0] hist;
  logic [FILL_W-1:0] fill;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else if (en) begin
      hist <= {hist[PAT_W-3:0], bit_in};
      if (fill != FILL_FULL) fill <= fill + FILL_W'(1);
    end
  end

  // History is kept after a match, which is what allows overlapping hits.
  assign match = en && (fill == FILL_FULL) && ({hist, bit_in} == pattern);

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Scan controller: serialises a captured word MSB-first into seq_det4 and
// reports the match count and first match position with a start/done handshake.
module pattern_scan_ctrl
  import pattern_scan_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic                clk,
  input  logic                rst,
  pattern_scan_ctrl_if.slave  bus
);

  state_t            state, state_nxt;
  logic              accept;
  logic              shifting;
  logic              last_bit;
  logic              det_match;

  logic [DATA_W-1:0] shreg;
  logic [PAT_W-1:0]  pat_q;
  logic [CNT_W-1:0]  idx;

  logic              hit_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              found_q;
  logic [CNT_W-1:0]  pos_q;

  assign shifting = (state == SHIFT);
  assign last_bit = (idx == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: defaults first so no path through the case leaves a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Word and pattern are captured once; later input changes are invisible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      pat_q <= '0;
      idx   <= '0;
    end else if (accept) begin
      shreg <= bus.data_in;
      pat_q <= bus.pattern;
      idx   <= '0;
    end else if (shifting) begin
      shreg <= {shreg[DATA_W-2:0], 1'b0};
      idx   <= idx + CNT_W'(1);
    end
  end

  seq_det4 u_det (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (shifting),
    .bit_in  (shreg[DATA_W-1]),
    .pattern (pat_q),
    .match   (det_match)
  );

  // Results are cleared only by an accepted start, so they hold after done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q   <= 1'b0;
      cnt_q   <= '0;
      found_q <= 1'b0;
      pos_q   <= '0;
    end else begin
      hit_q <= det_match;
      if (accept) begin
        cnt_q   <= '0;
        found_q <= 1'b0;
        pos_q   <= '0;
      end else if (det_match) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (!found_q) begin
          found_q <= 1'b1;
          pos_q   <= idx - CNT_W'(PAT_W - 1);
        end
      end
    end
  end

  assign bus.busy      = shifting;
  assign bus.done      = (state == DONE);
  assign bus.hit       = hit_q;
  assign bus.match_cnt = cnt_q;
  assign bus.found     = found_q;
  assign bus.first_pos = pos_q;

endmodule
